// File: rtl/training_data_loader.sv
// rtl/training_data_loader.sv - Byte-stream frame loader for the neural core sample memory
//
// Accepts a host byte stream framed as: 4-byte word count N, N little-endian
// 32-bit data words, 4-byte checksum (sum of data words mod 2^32). Data words
// are written sequentially from address 0 into a DEPTH x 32 memory that the
// processor reads through a registered, read-first port.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   rx_data         host byte
//   rx_valid        rx_data valid this cycle
//   rx_ready        loader accepts a byte this cycle (COUNT/DATA/CHECK)
//   clear           one-cycle pulse, leaves DONE/ERR for a new frame
//   address         processor read address
//   mem_data        registered read data for address (1-cycle latency)
//   busy            frame in progress (first byte accepted, not yet DONE/ERR)
//   load_done       frame loaded and checksum matched (level)
//   load_error      oversize count or checksum mismatch (level)
//   words_loaded    data words written in the current frame

module training_data_loader #(
    parameter int DEPTH = 2048,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    input  logic          clear,
    input  logic [AW-1:0] address,
    output logic [31:0]   mem_data,
    output logic          busy,
    output logic          load_done,
    output logic          load_error,
    output logic [AW:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_DATA  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   WL_ONE    = (AW + 1)'(1);
    localparam logic [31:0]   DEPTH_W   = 32'(DEPTH);

    state_t        state;
    state_t        state_next;

    logic [1:0]    byte_idx;
    logic [23:0]   shift;
    logic [31:0]   n_words;
    logic [AW-1:0] wr_addr;
    logic [31:0]   sum;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          last_byte;
    logic          wr_en;
    logic          clear_take;
    logic [31:0]   word;
    logic [31:0]   wl_next_w;

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        accept     = 1'b0;
        last_byte  = 1'b0;
        wr_en      = 1'b0;
        clear_take = 1'b0;
        busy       = 1'b0;
        load_done  = 1'b0;
        load_error = 1'b0;

        // Little-endian assembly: the incoming byte becomes bits [31:24]
        // because the three earlier bytes already sit in shift[23:0].
        word      = {rx_data, shift};
        wl_next_w = {{(31 - AW){1'b0}}, words_loaded} + 32'd1;

        rx_ready   = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
        accept     = rx_valid && rx_ready;
        last_byte  = accept && (byte_idx == 2'd3);
        load_done  = (state == S_DONE);
        load_error = (state == S_ERR);

        // In COUNT the frame has only started once a byte was taken.
        busy = (state == S_DATA) || (state == S_CHECK) ||
               ((state == S_COUNT) && (byte_idx != 2'd0));

        case (state)
            S_COUNT: begin
                if (last_byte) begin
                    if (word > DEPTH_W) begin
                        state_next = S_ERR;
                    end else if (word == 32'd0) begin
                        state_next = S_CHECK;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                wr_en = last_byte;
                if (last_byte && (wl_next_w == n_words)) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (last_byte) begin
                    state_next = (word == sum) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                clear_take = clear;
                if (clear) begin
                    state_next = S_COUNT;
                end
            end
            default: begin
                state_next = S_COUNT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_COUNT;
            byte_idx     <= 2'd0;
            shift        <= 24'd0;
            n_words      <= 32'd0;
            wr_addr      <= '0;
            words_loaded <= '0;
            sum          <= 32'd0;
        end else begin
            state <= state_next;

            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                shift    <= word[31:8];
            end

            if (last_byte && (state == S_COUNT)) begin
                n_words <= word;
            end

            // wr_addr is AW bits wide, so after word DEPTH it wraps to 0.
            if (wr_en) begin
                wr_addr      <= wr_addr + ADDR_ONE;
                words_loaded <= words_loaded + WL_ONE;
                sum          <= sum + word;
            end

            if (clear_take) begin
                byte_idx     <= 2'd0;
                shift        <= 24'd0;
                wr_addr      <= '0;
                words_loaded <= '0;
                sum          <= 32'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample memory: contents survive rst and clear
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= word;
        end
    end

    // Read-first: a same-edge write to the same address is not seen here.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_data <= 32'd0;
        end else begin
            mem_data <= mem[address];
        end
    end

endmodule

// File: tb/tb_training_data_loader.sv
// tb/tb_training_data_loader.sv - Self-checking bench for training_data_loader

module tb_training_data_loader;

    localparam int DEPTH = 2048;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        clear;
    logic [10:0] address;
    logic [31:0] mem_data;
    logic        busy;
    logic        load_done;
    logic        load_error;
    logic [11:0] words_loaded;

    int          n_asserts = 0;
    int          n_fail    = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] frame_words [$];

    training_data_loader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .clear        (clear),
        .address      (address),
        .mem_data     (mem_data),
        .busy         (busy),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int maxgap, input bit in_frame);
        int waited;
        if (maxgap > 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(maxgap, 0)) begin
                @(negedge clk);
                if (in_frame) check("busy_gap", {63'd0, busy}, 64'd1);
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (!rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) check("rx_ready_timeout", {63'd0, rx_ready}, 64'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Sends a whole frame built from n, frame_words and ck, then checks the
    // outcome the frame rules predict.
    task automatic send_frame(input logic [31:0] n, input logic [31:0] ck, input int maxgap);
        logic [7:0]  bq [$];
        logic [31:0] s;
        logic [31:0] w;
        bit          exp_done;
        bit          exp_err;
        int          exp_wl;
        check("busy_idle", {63'd0, busy}, 64'd0);
        for (int k = 0; k < 4; k++) bq.push_back(n[8*k +: 8]);
        if (n <= DEPTH) begin
            s = 32'd0;
            for (int i = 0; i < int'(n); i++) begin
                w = frame_words[i];
                for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
                ref_mem[i] = w;
                s = s + w;
            end
            for (int k = 0; k < 4; k++) bq.push_back(ck[8*k +: 8]);
            exp_done = (s == ck);
            exp_err  = !exp_done;
            exp_wl   = int'(n);
        end else begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            exp_wl   = 0;
        end
        for (int i = 0; i < bq.size(); i++) begin
            send_byte(bq[i], maxgap, i > 0);
            check("busy", {63'd0, busy}, (i != bq.size() - 1) ? 64'd1 : 64'd0);
        end
        check("load_done",    {63'd0, load_done},  {63'd0, exp_done});
        check("load_error",   {63'd0, load_error}, {63'd0, exp_err});
        check("words_loaded", {52'd0, words_loaded}, 64'(exp_wl));
        @(negedge clk);
        check("rx_ready_end", {63'd0, rx_ready}, 64'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_rx_ready",     {63'd0, rx_ready},   64'd1);
        check("clr_words_loaded", {52'd0, words_loaded}, 64'd0);
        check("clr_done",         {63'd0, load_done},  64'd0);
        check("clr_error",        {63'd0, load_error}, 64'd0);
    endtask

    task automatic read_chk(input int a);
        address = 11'(a);
        @(negedge clk);
        check($sformatf("mem_data[%0d]", a), {32'd0, mem_data}, {32'd0, ref_mem[a]});
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] w;
        int          n;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        clear    = 1'b0;
        address  = 11'd0;
        repeat (2) @(negedge clk);
        check("rst_rx_ready",     {63'd0, rx_ready},   64'd1);
        check("rst_busy",         {63'd0, busy},       64'd0);
        check("rst_done",         {63'd0, load_done},  64'd0);
        check("rst_error",        {63'd0, load_error}, 64'd0);
        check("rst_words_loaded", {52'd0, words_loaded}, 64'd0);
        check("rst_mem_data",     {32'd0, mem_data},   64'd0);
        rst = 1'b0;
        @(negedge clk);

        // N=3 good checksum, back-to-back
        frame_words = '{32'h0000_0002, 32'h0001_0000, 32'h0000_8000};
        send_frame(32'd3, 32'h0001_8002, 0);
        for (int a = 0; a < 3; a++) read_chk(a);
        do_clear();

        // Same frame, bad checksum
        send_frame(32'd3, 32'h0001_8003, 0);
        for (int a = 0; a < 3; a++) read_chk(a);
        do_clear();

        // N=0 frames
        frame_words = {};
        send_frame(32'd0, 32'd0, 0);
        do_clear();
        send_frame(32'd0, 32'd1, 0);
        do_clear();

        // Oversize count
        send_frame(32'h0000_0801, 32'd0, 0);
        do_clear();

        // Full-depth frame with random contents
        frame_words = {};
        s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom();
            frame_words.push_back(w);
            s = s + w;
        end
        send_frame(32'd2048, s, 0);
        read_chk(2047);
        read_chk(0);
        read_chk(int'($urandom_range(2046, 1)));
        do_clear();

        // N=2 with random valid gaps
        frame_words = {};
        s = 32'd0;
        for (int i = 0; i < 2; i++) begin
            w = $urandom();
            frame_words.push_back(w);
            s = s + w;
        end
        send_frame(32'd2, s, 5);
        read_chk(0);
        read_chk(1);
        do_clear();

        // Random short frames, some with corrupted checksums
        for (int f = 0; f < 4; f++) begin
            n = int'($urandom_range(16, 1));
            frame_words = {};
            s = 32'd0;
            for (int i = 0; i < n; i++) begin
                w = $urandom();
                frame_words.push_back(w);
                s = s + w;
            end
            send_frame(32'(n), (f % 2 == 1) ? s + 32'd1 : s, 2);
            read_chk(n - 1);
            do_clear();
        end

        // Reset after the 6th data byte of an N=2 frame
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h44, 0, 1'b1);
        send_byte(8'h33, 0, 1'b1);
        send_byte(8'h22, 0, 1'b1);
        send_byte(8'h11, 0, 1'b1);
        send_byte(8'h55, 0, 1'b1);
        send_byte(8'h66, 0, 1'b1);
        ref_mem[0] = 32'h1122_3344;
        check("partial_words_loaded", {52'd0, words_loaded}, 64'd1);
        read_chk(0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy",         {63'd0, busy},       64'd0);
        check("mid_rst_words_loaded", {52'd0, words_loaded}, 64'd0);
        check("mid_rst_rx_ready",     {63'd0, rx_ready},   64'd1);
        check("mid_rst_mem_data",     {32'd0, mem_data},   64'd0);
        rst = 1'b0;
        @(negedge clk);
        frame_words = '{32'hD00D_B00B};
        send_frame(32'd1, 32'hD00D_B00B, 0);
        read_chk(0);
        read_chk(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
